match_event_capture: RTL and testbench

- Sits directly downstream of match_filter in the inband RX path. Runs on the same clk/rxstrobe domain.
- Qualifies the filter's valid/match outputs into discrete match events. Each event is stamped with the RX timestamp at onset and with its run length in strobes.
- Events are buffered in a small FIFO for the RX packet builder, which reports detections to the host.

---
 rtl/mec_pkg.sv | 20 ++
 rtl/event_fifo.sv | 75 +++++++
 rtl/match_event_capture.sv | 169 ++++++++++++++++
 tb/tb_match_event_capture.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mec_pkg.sv
// mec_pkg: shared definitions for match_event_capture.
//   - FSM state encoding used by the capture controller.
//   - Default field widths and the event-record width helper.
package mec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IN_MATCH = 2'd1,
      ST_HOLDOFF  = 2'd2
   } mec_state_e;

   localparam int MEC_TS_WIDTH  = 32;
   localparam int MEC_LEN_WIDTH = 16;

   // One FIFO entry is {onset timestamp, run length}.
   function automatic int rec_width(input int ts_w, input int len_w);
      return ts_w + len_w;
   endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous first-word-fall-through FIFO for match events.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   push, wdata       write request and data; accepted when not full, or
//                     when full together with a pop
//   pop               read request; ignored while empty
//   rdata             head entry, zero while empty
//   full, empty       occupancy flags
//   count             exact occupancy, 0..DEPTH
module event_fifo
   import mec_pkg::*;
#(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en, rd_en;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // A pop frees the slot in the same cycle, so a push into a full FIFO
   // alongside a pop is still accepted.
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/match_event_capture.sv
// match_event_capture: turns match_filter valid/match samples into discrete
// timestamped match events and queues them for the RX packet builder.
// Ports:
//   clk, reset          RX clock, asynchronous active-low reset
//   rxstrobe, valid     sample qualifier (sample = rxstrobe && valid)
//   match               correlation hit for the current sample
//   timestamp           free-running RX sample timestamp
//   enable              capture enable
//   holdoff             samples ignored after an event closes
//   rd_en               pop request for the head event
//   clear_ovf           clears overflow and drop_cnt
//   ev_valid/ev_ts/ev_len  head event (first-word-fall-through)
//   ev_count            queue occupancy
//   overflow, drop_cnt  sticky drop flag and saturating drop count
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_IDLE     | waiting for an enabled hit to open an event
// ST_IN_MATCH | event open; counting consecutive hit samples
// ST_HOLDOFF  | event closed; hcnt samples ignored before re-arm
module match_event_capture
   import mec_pkg::*;
#(
   parameter int TS_WIDTH  = MEC_TS_WIDTH,
   parameter int LEN_WIDTH = MEC_LEN_WIDTH,
   parameter int DEPTH     = 8,
   parameter int AW        = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rxstrobe,
   input  logic                 valid,
   input  logic                 match,
   input  logic [TS_WIDTH-1:0]  timestamp,
   input  logic                 enable,
   input  logic [15:0]          holdoff,
   input  logic                 rd_en,
   input  logic                 clear_ovf,
   output logic                 ev_valid,
   output logic [TS_WIDTH-1:0]  ev_ts,
   output logic [LEN_WIDTH-1:0] ev_len,
   output logic [AW:0]          ev_count,
   output logic                 overflow,
   output logic [7:0]           drop_cnt
);

   localparam int REC_W = rec_width(TS_WIDTH, LEN_WIDTH);

   mec_state_e           state_q, state_d;
   logic [TS_WIDTH-1:0]  cur_ts_q, cur_ts_d;
   logic [LEN_WIDTH-1:0] cur_len_q, cur_len_d;
   logic [15:0]          hcnt_q, hcnt_d;
   logic                 push_q, push_d;
   logic [REC_W-1:0]     rec_q, rec_d;
   logic                 overflow_q, overflow_d;
   logic [7:0]           drop_cnt_q, drop_cnt_d;

   logic                 sample, hit, drop;
   logic                 fifo_full, fifo_empty;
   logic [REC_W-1:0]     fifo_rdata;

   assign sample = rxstrobe && valid;
   assign hit    = sample && match;

   always_comb begin
      state_d   = state_q;
      cur_ts_d  = cur_ts_q;
      cur_len_d = cur_len_q;
      hcnt_d    = hcnt_q;
      push_d    = 1'b0;
      rec_d     = rec_q;
      case (state_q)
         ST_IDLE: begin
            if (hit && enable) begin
               cur_ts_d  = timestamp;
               cur_len_d = LEN_WIDTH'(1);
               state_d   = ST_IN_MATCH;
            end
         end
         ST_IN_MATCH: begin
            // Losing enable closes the open event before any sample rule.
            if (!enable) begin
               push_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (hit) begin
               if (cur_len_q != '1) cur_len_d = cur_len_q + LEN_WIDTH'(1);
            end else if (sample) begin
               push_d = 1'b1;
               if (holdoff == 16'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  hcnt_d  = holdoff;
                  state_d = ST_HOLDOFF;
               end
            end
         end
         ST_HOLDOFF: begin
            if (!enable) begin
               hcnt_d  = '0;
               state_d = ST_IDLE;
            end else if (sample) begin
               hcnt_d = hcnt_q - 16'd1;
               if (hcnt_q == 16'd1) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (push_d) rec_d = {cur_ts_q, cur_len_q};
   end

   // A pop in the same cycle makes room, so only an unpaired push is lost.
   assign drop = push_q && fifo_full && !rd_en;

   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (clear_ovf) begin
         overflow_d = drop;
         drop_cnt_d = drop ? 8'd1 : 8'd0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cur_ts_q   <= '0;
         cur_len_q  <= '0;
         hcnt_q     <= '0;
         push_q     <= 1'b0;
         rec_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_ts_q   <= cur_ts_d;
         cur_len_q  <= cur_len_d;
         hcnt_q     <= hcnt_d;
         push_q     <= push_d;
         rec_q      <= rec_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   event_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_q),
      .pop   (rd_en),
      .wdata (rec_q),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (ev_count)
   );

   assign ev_valid        = !fifo_empty;
   assign {ev_ts, ev_len} = fifo_rdata;
   assign overflow        = overflow_q;
   assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_match_event_capture.sv
// tb_match_event_capture: directed bench for match_event_capture with a
// 4-bit run-length field so saturation is reachable in a short run.
module tb_match_event_capture;

   localparam int TSW   = 32;
   localparam int LW    = 4;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic           rxstrobe, valid, match;
   logic [TSW-1:0] timestamp;
   logic           enable;
   logic [15:0]    holdoff;
   logic           rd_en, clear_ovf;
   logic           ev_valid;
   logic [TSW-1:0] ev_ts;
   logic [LW-1:0]  ev_len;
   logic [AW:0]    ev_count;
   logic           overflow;
   logic [7:0]     drop_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] ts_log [16];
   int          len_log [16];
   logic [31:0] t, ts2, ts5, ts6;
   int          order [8];

   always #5 clk = ~clk;

   match_event_capture #(
      .TS_WIDTH  (TSW),
      .LEN_WIDTH (LW),
      .DEPTH     (DEPTH),
      .AW        (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rxstrobe  (rxstrobe),
      .valid     (valid),
      .match     (match),
      .timestamp (timestamp),
      .enable    (enable),
      .holdoff   (holdoff),
      .rd_en     (rd_en),
      .clear_ovf (clear_ovf),
      .ev_valid  (ev_valid),
      .ev_ts     (ev_ts),
      .ev_len    (ev_len),
      .ev_count  (ev_count),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      timestamp = timestamp + 32'd1;
   endtask

   // One sample every 16 clocks; returns the timestamp the DUT sees.
   task automatic samp(input logic m, output logic [31:0] ts_at);
      repeat (15) tick();
      rxstrobe = 1'b1;
      valid    = 1'b1;
      match    = m;
      ts_at    = timestamp;
      tick();
      rxstrobe = 1'b0;
      valid    = 1'b0;
      match    = 1'b0;
   endtask

   task automatic gen_event(input int len, output logic [31:0] ts0);
      logic [31:0] tt;
      ts0 = '0;
      for (int i = 0; i < len; i++) begin
         samp(1'b1, tt);
         if (i == 0) ts0 = tt;
      end
      samp(1'b0, tt);
   endtask

   initial begin
      reset = 1'b0; rxstrobe = 1'b0; valid = 1'b0; match = 1'b0;
      timestamp = '0; enable = 1'b0; holdoff = 16'd4;
      rd_en = 1'b0; clear_ovf = 1'b0;
      repeat (3) tick();
      check_eq("rst_ev_valid", 32'(ev_valid), 0);
      check_eq("rst_ev_count", 32'(ev_count), 0);
      check_eq("rst_overflow", 32'(overflow), 0);
      check_eq("rst_drop_cnt", 32'(drop_cnt), 0);
      check_eq("rst_ev_ts",    ev_ts, 0);
      check_eq("rst_ev_len",   32'(ev_len), 0);
      reset  = 1'b1;
      enable = 1'b1;
      repeat (2) tick();

      // Single event, onset at timestamp 1000, three hits.
      timestamp = 32'd985;
      samp(1'b1, t); samp(1'b1, t); samp(1'b1, t); samp(1'b0, t);
      check_eq("t1_valid_1clk", 32'(ev_valid), 0);
      tick();
      check_eq("t1_valid_2clk", 32'(ev_valid), 1);
      check_eq("t1_ev_ts",      ev_ts, 1000);
      check_eq("t1_ev_len",     32'(ev_len), 3);
      check_eq("t1_ev_count",   32'(ev_count), 1);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      check_eq("t1_pop_count",  32'(ev_count), 0);
      check_eq("t1_pop_valid",  32'(ev_valid), 0);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      check_eq("t1_empty_pop",  32'(ev_count), 0);

      // Holdoff of 4: hit on 2nd sample ignored, hit on 5th opens.
      samp(1'b0, t); samp(1'b1, t); samp(1'b0, t); samp(1'b0, t);
      repeat (2) tick();
      check_eq("t2_no_event",   32'(ev_count), 0);
      samp(1'b1, ts2); samp(1'b0, t);
      repeat (2) tick();
      check_eq("t2_new_count",  32'(ev_count), 1);
      check_eq("t2_new_ts",     ev_ts, ts2);
      check_eq("t2_new_len",    32'(ev_len), 1);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      enable = 1'b0; tick(); enable = 1'b1;
      holdoff = 16'd0;

      // Ten events into an 8-deep queue with no reads.
      for (int e = 0; e < 10; e++) begin
         len_log[e] = (e % 3) + 1;
         gen_event(len_log[e], ts_log[e]);
      end
      repeat (2) tick();
      check_eq("t3_count",      32'(ev_count), 8);
      check_eq("t3_overflow",   32'(overflow), 1);
      check_eq("t3_drop_cnt",   32'(drop_cnt), 2);
      check_eq("t3_head_ts",    ev_ts, ts_log[0]);
      check_eq("t3_head_len",   32'(ev_len), 1);

      // Clear coinciding with a drop leaves overflow=1, drop_cnt=1.
      len_log[10] = 2;
      gen_event(2, ts_log[10]);
      clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
      check_eq("t3_clr_ovf",    32'(overflow), 1);
      check_eq("t3_clr_drop",   32'(drop_cnt), 1);
      check_eq("t3_clr_count",  32'(ev_count), 8);

      // Full queue: push and pop in the same cycle.
      len_log[11] = 3;
      gen_event(3, ts_log[11]);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      check_eq("t4_count",      32'(ev_count), 8);
      check_eq("t4_drop_cnt",   32'(drop_cnt), 1);
      check_eq("t4_head_ts",    ev_ts, ts_log[1]);
      check_eq("t4_head_len",   32'(ev_len), 2);

      order = '{1, 2, 3, 4, 5, 6, 7, 11};
      for (int k = 0; k < 8; k++) begin
         check_eq($sformatf("t4_drain_ts%0d", k),  ev_ts, ts_log[order[k]]);
         check_eq($sformatf("t4_drain_len%0d", k), 32'(ev_len), 32'(len_log[order[k]]));
         rd_en = 1'b1; tick(); rd_en = 1'b0;
      end
      check_eq("t4_drained",    32'(ev_count), 0);
      check_eq("t4_ovf_sticky", 32'(overflow), 1);

      // Saturation at 15 with 20 hits, closed by dropping enable.
      gen_event(0, t);
      samp(1'b1, ts5);
      for (int i = 1; i < 20; i++) samp(1'b1, t);
      repeat (2) tick();
      check_eq("t5_no_push",    32'(ev_count), 0);
      enable = 1'b0; tick(); enable = 1'b1;
      tick();
      check_eq("t5_count",      32'(ev_count), 1);
      check_eq("t5_len_sat",    32'(ev_len), 15);
      check_eq("t5_ts",         ev_ts, ts5);
      rd_en = 1'b1; tick(); rd_en = 1'b0;

      // Reset in IN_MATCH with three events queued.
      for (int e = 0; e < 3; e++) gen_event(1, t);
      repeat (2) tick();
      check_eq("t6_pre_count",  32'(ev_count), 3);
      samp(1'b1, t); samp(1'b1, t);
      reset = 1'b0;
      #1;
      check_eq("t6_rst_count",  32'(ev_count), 0);
      check_eq("t6_rst_valid",  32'(ev_valid), 0);
      check_eq("t6_rst_ts",     ev_ts, 0);
      check_eq("t6_rst_len",    32'(ev_len), 0);
      check_eq("t6_rst_ovf",    32'(overflow), 0);
      check_eq("t6_rst_drop",   32'(drop_cnt), 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      gen_event(2, ts6);
      repeat (2) tick();
      check_eq("t6_new_count",  32'(ev_count), 1);
      check_eq("t6_new_len",    32'(ev_len), 2);
      check_eq("t6_new_ts",     ev_ts, ts6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
